wb_result_sel_bist: RTL and testbench

- Parametrised, self-testing N-source writeback result selector.
- Successor to the fixed 2:1 hardened result mux.
- Picks one of NUM_SRC writeback sources (ALU, load data, PC+4, immediate, ...) onto the register-file write bus.
- Checks itself every cycle with a redundant shadow mux and counts faults.
- On request, runs an internal walking-pattern BIST across every source leg while the pipeline is stalled.

---
 rtl/wb_result_sel_bist.sv | 238 +++++++++++++++++++++++
 tb/tb_wb_result_sel_bist.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_sel_bist.sv
// wb_result_sel_bist: N-source writeback result selector with a
// shadow-mux self check, fault logging and a walking-pattern BIST.
module wb_result_sel_bist #(
  parameter int WIDTH       = 32,
  parameter int NUM_SRC     = 4,
  parameter int SEL_W       = 2,
  parameter int FAULT_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     test_en_in,
  input  logic [NUM_SRC*WIDTH-1:0] src_bus,
  input  logic [SEL_W-1:0]         sel,
  input  logic [WIDTH-1:0]         inject_mask,
  input  logic                     fault_clr,
  output logic [WIDTH-1:0]         result,
  output logic                     bist_busy,
  output logic                     bist_done,
  output logic                     bist_pass,
  output logic                     fault_sticky,
  output logic [SEL_W-1:0]         fault_src,
  output logic [FAULT_CNT_W-1:0]   fault_count
);

  localparam int STEP_W = SEL_W + 2;
  localparam logic [STEP_W-1:0] LAST_STEP =
    STEP_W'(NUM_SRC * 4 - 1);

  // Alternating pattern: odd=1 gives 0xAA.., odd=0 gives 0x55..
  function automatic logic [WIDTH-1:0] alt_pat(input logic odd);
    logic [WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) begin
      p[i] = (odd == 1'(i % 2));
    end
    return p;
  endfunction

  localparam logic [WIDTH-1:0] PAT_AA = alt_pat(1'b1);
  localparam logic [WIDTH-1:0] PAT_55 = alt_pat(1'b0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [STEP_W-1:0]      step_q, step_d;
  logic                   err_q, err_d;
  logic                   pass_q, pass_d;
  logic                   sticky_q, sticky_d;
  logic [SEL_W-1:0]       src_q, src_d;
  logic [FAULT_CNT_W-1:0] count_q, count_d;

  logic                     busy;
  logic                     in_run;
  logic [SEL_W-1:0]         leg;
  logic [1:0]               pat_idx;
  logic [WIDTH-1:0]         cur_pat;
  logic [NUM_SRC*WIDTH-1:0] test_bus;
  logic [NUM_SRC*WIDTH-1:0] mux_bus;
  logic [SEL_W-1:0]         mux_sel;
  logic                     in_range;
  logic [NUM_SRC-1:0]       onehot;
  logic [WIDTH-1:0]         prim_raw;
  logic [WIDTH-1:0]         prim;
  logic [WIDTH-1:0]         shadow;
  logic                     miss_mission;
  logic                     miss_bist;
  logic                     mismatch;
  logic [SEL_W-1:0]         log_src;

  assign leg     = step_q[STEP_W-1:2];
  assign pat_idx = step_q[1:0];

  // Current walking pattern for this BIST step
  always_comb begin
    cur_pat = '0;
    unique case (pat_idx)
      2'd0:    cur_pat = '0;
      2'd1:    cur_pat = '1;
      2'd2:    cur_pat = PAT_AA;
      default: cur_pat = PAT_55;
    endcase
  end

  // Test stimulus: pattern on the leg under test, inverse elsewhere
  always_comb begin
    test_bus = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(leg) == k) begin
        test_bus[k*WIDTH +: WIDTH] = cur_pat;
      end else begin
        test_bus[k*WIDTH +: WIDTH] = ~cur_pat;
      end
    end
  end

  assign mux_bus  = in_run ? test_bus : src_bus;
  assign mux_sel  = in_run ? leg : sel;
  assign in_range = int'(mux_sel) < NUM_SRC;

  // Primary mux: priority compare on the select value
  always_comb begin
    prim_raw = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(mux_sel) == k) begin
        prim_raw = mux_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  assign prim   = prim_raw ^ inject_mask;
  assign onehot = NUM_SRC'(1) << mux_sel;

  // Shadow mux: independent one-hot AND-OR structure
  always_comb begin
    shadow = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      shadow = shadow |
        (mux_bus[k*WIDTH +: WIDTH] & {WIDTH{onehot[k]}});
    end
  end

  assign miss_mission = !busy &&
    ((prim != shadow) || !in_range);
  assign miss_bist = in_run &&
    ((prim != cur_pat) || (shadow != cur_pat));
  assign mismatch = miss_mission || miss_bist;
  assign log_src  = in_run ? leg : sel;

  assign result = (rst || busy || !in_range) ? '0 : prim;

  // BIST state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // BIST next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (test_en_in) state_d = RUN;
      RUN: begin
        if (!test_en_in) begin
          state_d = IDLE;
        end else if (step_q == LAST_STEP) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // BIST outputs, step counter, error flag and pass flag
  always_comb begin
    busy   = 1'b0;
    in_run = 1'b0;
    step_d = step_q;
    err_d  = err_q;
    pass_d = pass_q;
    bist_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        step_d = '0;
        err_d  = 1'b0;
      end
      RUN: begin
        busy   = 1'b1;
        in_run = 1'b1;
        step_d = step_q + 1'b1;
        err_d  = err_q | miss_bist;
        if (!test_en_in) pass_d = 1'b0;
      end
      DONE: begin
        busy      = 1'b1;
        bist_done = 1'b1;
        step_d    = '0;
        pass_d    = ~err_q;
      end
      default: begin
        step_d = '0;
      end
    endcase
  end

  assign bist_busy = busy;

  // Fault log: a mismatch in the clearing cycle still records
  always_comb begin
    sticky_d = sticky_q;
    src_d    = src_q;
    count_d  = count_q;
    if (fault_clr) begin
      sticky_d = 1'b0;
      src_d    = '0;
      count_d  = '0;
    end
    if (mismatch) begin
      sticky_d = 1'b1;
      if (fault_clr || !sticky_q) src_d = log_src;
      if (count_d != {FAULT_CNT_W{1'b1}}) begin
        count_d = count_d + 1'b1;
      end
    end
  end

  // Datapath state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= '0;
      err_q    <= 1'b0;
      pass_q   <= 1'b0;
      sticky_q <= 1'b0;
      src_q    <= '0;
      count_q  <= '0;
    end else begin
      step_q   <= step_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      sticky_q <= sticky_d;
      src_q    <= src_d;
      count_q  <= count_d;
    end
  end

  assign bist_pass    = pass_q;
  assign fault_sticky = sticky_q;
  assign fault_src    = src_q;
  assign fault_count  = count_q;

endmodule

// File: tb/tb_wb_result_sel_bist.sv
// tb_wb_result_sel_bist: directed bench with a cycle model of the
// selector, BIST sequencer and fault log, plus literal checks.
module tb_wb_result_sel_bist;

  logic         clk = 1'b0;
  logic         rst;
  logic         test_en_in;
  logic [127:0] src_bus;
  logic [1:0]   sel;
  logic [31:0]  inject_mask;
  logic         fault_clr;
  logic [31:0]  result;
  logic         bist_busy, bist_done, bist_pass;
  logic         fault_sticky;
  logic [1:0]   fault_src;
  logic [7:0]   fault_count;

  logic [95:0]  src_b;
  logic [1:0]   sel_b;
  logic [31:0]  result_b;
  logic         busy_b, done_b, pass_b, sticky_b;
  logic [1:0]   fsrc_b;
  logic [7:0]   cnt_b;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  wb_result_sel_bist dut (
    .clk(clk), .rst(rst), .test_en_in(test_en_in),
    .src_bus(src_bus), .sel(sel), .inject_mask(inject_mask),
    .fault_clr(fault_clr), .result(result),
    .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_pass(bist_pass), .fault_sticky(fault_sticky),
    .fault_src(fault_src), .fault_count(fault_count)
  );

  wb_result_sel_bist #(.NUM_SRC(3)) dut_b (
    .clk(clk), .rst(rst), .test_en_in(1'b0),
    .src_bus(src_b), .sel(sel_b), .inject_mask(32'h0),
    .fault_clr(1'b0), .result(result_b),
    .bist_busy(busy_b), .bist_done(done_b),
    .bist_pass(pass_b), .fault_sticky(sticky_b),
    .fault_src(fsrc_b), .fault_count(cnt_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: -1 idle, 0..15 run step, 16 done
  int   m_step = -1;
  bit   m_err = 0, m_pass = 0, m_sticky = 0;
  int   m_cnt = 0;
  logic [1:0] m_src = 0;

  always @(posedge clk) begin
    bit mm;
    int cs;
    if (rst) begin
      m_step = -1; m_err = 0; m_pass = 0;
      m_sticky = 0; m_cnt = 0; m_src = 0;
    end else begin
      if (m_step < 0) begin
        mm = (int'(sel) >= 4) || (inject_mask != 0);
        cs = int'(sel);
      end else if (m_step < 16) begin
        mm = (inject_mask != 0);
        cs = m_step / 4;
      end else begin
        mm = 0;
        cs = 0;
      end
      if (fault_clr) begin
        m_sticky = 0; m_cnt = 0; m_src = 0;
      end
      if (mm) begin
        if (!m_sticky) m_src = cs[1:0];
        m_sticky = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if (m_step < 0) begin
        if (test_en_in) begin m_step = 0; m_err = 0; end
      end else if (m_step < 16) begin
        if (mm) m_err = 1;
        if (!test_en_in) begin
          m_step = -1; m_pass = 0;
        end else begin
          m_step++;
        end
      end else begin
        m_pass = !m_err;
        m_step = -1;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] er;
    if (chk_on) begin
      if (rst || m_step >= 0) er = 32'h0;
      else er = src_bus[int'(sel)*32 +: 32] ^ inject_mask;
      chk("m_result", result, er);
      chk("m_busy", 32'(bist_busy), 32'(m_step >= 0));
      chk("m_done", 32'(bist_done), 32'(m_step == 16));
      chk("m_pass", 32'(bist_pass), 32'(m_pass));
      chk("m_sticky", 32'(fault_sticky), 32'(m_sticky));
      chk("m_src", 32'(fault_src), 32'(m_src));
      chk("m_cnt", 32'(fault_count), 32'(m_cnt));
    end
  end

  task automatic run_bist(input logic [31:0] inj,
                          output int nb, output int nd,
                          output int rnz);
    bit fin;
    nb = 0; nd = 0; rnz = 0; fin = 0;
    @(negedge clk);
    test_en_in = 1'b1;
    @(posedge clk);
    #1 inject_mask = inj;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bist_busy) begin
        nb++;
        if (result != 0) rnz++;
      end
      if (bist_done) begin
        nd++;
        test_en_in  = 1'b0;
        inject_mask = 32'h0;
      end
      if (nd > 0 && !bist_busy) begin
        fin = 1;
        break;
      end
    end
    chk("bist_finish", 32'(fin), 32'd1);
    test_en_in  = 1'b0;
    inject_mask = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd, rnz, ad;
    rst = 1'b1;
    test_en_in = 1'($urandom);
    src_bus = {$urandom, $urandom, $urandom, $urandom};
    src_b = {$urandom, $urandom, $urandom};
    sel = 2'($urandom); sel_b = 2'($urandom);
    inject_mask = $urandom; fault_clr = 1'($urandom);
    @(posedge clk);
    #1 chk_on = 1'b1;
    src_bus = {$urandom, $urandom, $urandom, $urandom | 1};
    sel = 2'd0; inject_mask = $urandom;
    @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_busy", 32'(bist_busy), 32'h0);
    chk("rst_cnt", 32'(fault_count), 32'h0);
    chk("rst_result_b", result_b, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0; test_en_in = 1'b0; fault_clr = 1'b0;
    inject_mask = 32'h0; sel = 2'd0; src_bus = '0;
    sel_b = 2'd0; src_b = '0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bist_busy), 32'h0);

    @(posedge clk);
    #1 src_bus = {32'h0, 32'h4, 32'hDEADBEEF, 32'h0};
    sel = 2'd1;
    #1 chk("sel1_result", result, 32'hDEADBEEF);
    sel = 2'd2;
    #1 chk("sel2_result", result, 32'h4);
    @(posedge clk);
    #1 chk("sel_sticky", 32'(fault_sticky), 32'h0);

    sel = 2'd0; src_bus[31:0] = 32'h10; inject_mask = 32'h1;
    #1 chk("inj_result", result, 32'h11);
    @(posedge clk);
    #1 inject_mask = 32'h0;
    @(negedge clk);
    chk("inj_sticky", 32'(fault_sticky), 32'h1);
    chk("inj_cnt", 32'(fault_count), 32'h1);
    chk("inj_src", 32'(fault_src), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("persist_cnt", 32'(fault_count), 32'h1);
    @(posedge clk);
    #1 fault_clr = 1'b1;
    @(posedge clk);
    #1 fault_clr = 1'b0;
    @(negedge clk);
    chk("clr_sticky", 32'(fault_sticky), 32'h0);
    chk("clr_cnt", 32'(fault_count), 32'h0);

    sel = 2'd1;
    run_bist(32'h0, nb, nd, rnz);
    chk("b1_busy_cycles", nb, 32'd17);
    chk("b1_done_pulses", nd, 32'd1);
    chk("b1_result_nz", rnz, 32'd0);
    chk("b1_pass", 32'(bist_pass), 32'h1);
    chk("b1_cnt", 32'(fault_count), 32'h0);

    sel = 2'd0;
    run_bist(32'h80000000, nb, nd, rnz);
    chk("b2_done_pulses", nd, 32'd1);
    chk("b2_pass", 32'(bist_pass), 32'h0);
    chk("b2_sticky", 32'(fault_sticky), 32'h1);
    chk("b2_src", 32'(fault_src), 32'h0);
    chk("b2_cnt", 32'(fault_count), 32'd16);
    @(posedge clk);
    #1 fault_clr = 1'b1;
    @(posedge clk);
    #1 fault_clr = 1'b0;

    run_bist(32'h0, nb, nd, rnz);
    chk("b3_pass", 32'(bist_pass), 32'h1);
    @(negedge clk);
    test_en_in = 1'b1;
    ad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bist_done) ad++;
    end
    chk("abort_step5_busy", 32'(bist_busy), 32'h1);
    test_en_in = 1'b0;
    @(negedge clk);
    if (bist_done) ad++;
    chk("abort_busy", 32'(bist_busy), 32'h0);
    chk("abort_done", ad, 32'd0);
    chk("abort_pass", 32'(bist_pass), 32'h0);

    @(posedge clk);
    #1 src_b = {32'h33, 32'h22, 32'h11};
    sel_b = 2'd2;
    #1 chk("b_sel2_result", result_b, 32'h33);
    sel_b = 2'd3;
    #1 chk("b_sel3_result", result_b, 32'h0);
    @(posedge clk);
    #1 sel_b = 2'd0;
    @(negedge clk);
    chk("b_sticky", 32'(sticky_b), 32'h1);
    chk("b_src", 32'(fsrc_b), 32'h3);
    chk("b_cnt", 32'(cnt_b), 32'h1);

    @(posedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
